bnn_seq: RTL and testbench
==========================

# bnn_seq

Sequential, parametrised binarised neural network classifier. It accepts a streamed image one pixel per handshake and binarises each pixel against a threshold. It then evaluates an input layer, DEPTH-1 hidden layers and an output layer using serial XNOR-popcount, one weight bit per cycle. It presents a per-class firing vector plus an argmax class index. Weights and biases are runtime-loadable, and the block sits between the pixel source and the result consumer in the classifier datapath.

## Interface
- N_IN, 784: pixels per image (input-layer fan-in)
- N_MID, 16: neurons per hidden layer
- N_OUT, 10: output classes
- DEPTH, 2: number of N_MID-wide layers (≥1)
- PIX_W, 8: pixel width
- PIX_TH, 64: pixel binarises to 1 iff pix > PIX_TH
- CW, 16: accumulator/bias width; must satisfy 2^CW > N_IN
- clk  in  1  clock
- xrst  in  1  reset: one clock; reset is synchronous and active-low
- pix  in  PIX_W  pixel data
- pix_valid  in  1  pixel strobe
- pix_ready  out  1  block accepts pixel this cycle
- cfg_we  in  1  weight-bit write
- cfg_waddr  in  32  flat weight-bit address
- cfg_wbit  in  1  weight bit
- cfg_be  in  1  bias write
- cfg_baddr  in  16  flat bias address
- cfg_bias  in  CW  bias value (unsigned)
- busy  out  1  high outside LOAD
- pred  out  N_OUT  pred[k] = output neuron k fired
- pred_idx  out  clog2(N_OUT)  argmax class
- pred_valid  out  1  one-cycle result strobe

## Operation
- States: LOAD → COMPUTE → DONE → LOAD.
- **LOAD**
  - pix_ready=1.
  - Each handshake (pix_valid & pix_ready) stores bit (pix > PIX_TH) at img[pcnt] and increments pcnt.
  - The handshake with pcnt = N_IN-1 moves the block to COMPUTE and clears pcnt.
- **COMPUTE**
  - Layers are evaluated in order: layer 0 (N_IN→N_MID), layers 1..DEPTH-1 (N_MID→N_MID), then output (N_MID→N_OUT).
  - For each neuron n:
    - acc clears.
    - For i = 0..fan_in-1, acc += (W[n][i] == x[i]), one bit per cycle.
    - One fire cycle follows: sum = acc + bias in CW+1 bits with no wrap; neuron output = (sum > fan_in/2), using floor division.
  - Outputs go to an activation buffer. A layer's inputs are the previous layer's complete outputs; use ping-pong buffers, never partially overwritten.
  - Output-layer sums are also compared for argmax. A strictly greater sum replaces the running max, so ties go to the lowest index.
- **DONE**
  - pred, pred_idx and pred_valid=1 are registered for one cycle.
  - The block then returns to LOAD.
- **Weight address map** (flat bit index)
  - Layer 0: n·N_IN+i.
  - Hidden layer l: N_MID·N_IN + (l-1)·N_MID² + n·N_MID + i.
  - Output: N_MID·N_IN + (DEPTH-1)·N_MID² + n·N_MID + i.
- **Bias address map**
  - Layer l<DEPTH: l·N_MID+n.
  - Output: DEPTH·N_MID+n.
- **Config writes**
  - Accepted only in LOAD with pcnt=0.
  - Ignored otherwise, and ignored for out-of-range addresses.
  - Weight and bias storage is not reset.
- **Reset** (xrst=0 at a clock edge)
  - state=LOAD, pcnt=0, pred=0, pred_idx=0, pred_valid=0, busy=0.
  - pix_ready=0 while xrst=0.
  - A reset during COMPUTE aborts it; no pred_valid is produced. Stored weights and biases are retained.

## Timing
- Last pixel handshake at cycle 0; COMPUTE begins at cycle 1.
- L = N_MID·(N_IN+1) + (DEPTH-1)·N_MID·(N_MID+1) + N_OUT·(N_MID+1). Defaults: 12560+272+170 = 13002.
- pred_valid is high in cycle L+1 only, and pix_ready returns to 1 in cycle L+2.
- pred and pred_idx hold their values until the next DONE or reset.
- pix_ready=0 and busy=1 from cycle 1 through L+1. pix_valid in that window is ignored, with no pixel lost or counted.
- Pixel gaps (pix_valid=0) stall LOAD indefinitely with no state change.

## Test plan
- Reset: hold xrst=0 for 3 cycles → pred=0, pred_idx=0, pred_valid=0, pix_ready=0; cycle after release → pix_ready=1, busy=0.
- All weights 1, all biases 0, 784 pixels of 255 → every neuron fires; pred=10'h3FF, pred_idx=0, pred_valid high exactly at cycle 13003 after the last handshake, one cycle wide.
- Same weights, 784 pixels of 64 → all bits 0; layer 0 acc=0, nothing fires downstream → pred=0, pred_idx=0. Then pixel value 65 ×784 → pred=10'h3FF.
- Boundary: layer-0 neuron 0 weights set so exactly 392 inputs match, bias 0 → neuron 0 silent. Bias 1 → fires. Output bias 5 on class 7, others 0, all-ones network → pred_idx=7.
- Random pix_valid gaps and pix_valid held high during COMPUTE → result identical to the gap-free run; no extra pixels consumed.
- Reset at cycle 5000 of COMPUTE → no pred_valid. Next image gives the correct result with retained weights. cfg_we pulses during COMPUTE leave weights unchanged.

Source files
------------

// File: rtl/bnn_seq.sv
// Sequential binarised neural network classifier: streams in a thresholded image,
// then evaluates every layer with bit-serial XNOR-popcount and reports per-class fires plus argmax.
module bnn_seq #(
  parameter int N_IN   = 784,
  parameter int N_MID  = 16,
  parameter int N_OUT  = 10,
  parameter int DEPTH  = 2,
  parameter int PIX_W  = 8,
  parameter int PIX_TH = 64,
  parameter int CW     = 16
) (
  input  logic                       clk,
  input  logic                       xrst,
  input  logic [PIX_W-1:0]           pix,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic                       cfg_we,
  input  logic [31:0]                cfg_waddr,
  input  logic                       cfg_wbit,
  input  logic                       cfg_be,
  input  logic [15:0]                cfg_baddr,
  input  logic [CW-1:0]              cfg_bias,
  output logic                       busy,
  output logic [N_OUT-1:0]           pred,
  output logic [$clog2(N_OUT)-1:0]   pred_idx,
  output logic                       pred_valid
);

  localparam int W_TOT = N_MID * N_IN + (DEPTH - 1) * N_MID * N_MID + N_OUT * N_MID;
  localparam int B_TOT = DEPTH * N_MID + N_OUT;
  localparam int NMAX  = (N_MID > N_OUT) ? N_MID : N_OUT;
  localparam int IW    = $clog2(N_IN + 1);
  localparam int NW    = $clog2(NMAX);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int WAW   = $clog2(W_TOT + 1);
  localparam int BAW   = $clog2(B_TOT + 1);
  localparam int MW    = (N_MID > 1) ? $clog2(N_MID) : 1;
  localparam int XW    = $clog2(N_OUT);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic            r_img  [N_IN];
  logic            r_wmem [W_TOT];
  logic [CW-1:0]   r_bmem [B_TOT];
  logic            r_xq, r_wq;
  logic [CW-1:0]   r_bq;

  logic [IW-1:0]   r_pcnt, r_i;
  logic [LW-1:0]   r_layer;
  logic [NW-1:0]   r_n;
  logic            r_fire;
  logic [CW-1:0]   r_acc;
  logic [WAW-1:0]  r_widx;
  logic [BAW-1:0]  r_bidx;
  logic [CW:0]     r_max;
  logic [XW-1:0]   r_idx, r_pred_idx;
  logic [N_OUT-1:0] r_ovec, r_pred;
  logic            r_pred_valid;
  logic [N_MID-1:0] r_act0, r_act1;

  logic            w_hs, w_last_pix, w_out_layer, w_last_i, w_last_n, w_done_fire;
  logic            w_x, w_fire, w_take, w_cfg_ok;
  logic [IW-1:0]   w_fan_in, w_i_next;
  logic [WAW-1:0]  w_widx_next;
  logic [CW:0]     w_sum, w_half;
  logic [N_OUT-1:0] w_ovec_new;

  assign pix_ready   = xrst && (r_state == S_LOAD);
  assign busy        = (r_state != S_LOAD);
  assign pred        = r_pred;
  assign pred_idx    = r_pred_idx;
  assign pred_valid  = r_pred_valid;

  assign w_hs        = pix_valid && pix_ready;
  assign w_last_pix  = (r_pcnt == IW'(N_IN - 1));
  assign w_out_layer = (r_layer == LW'(DEPTH));
  assign w_fan_in    = (r_layer == '0) ? IW'(N_IN) : IW'(N_MID);
  assign w_last_i    = (r_i == w_fan_in - IW'(1));
  assign w_last_n    = (r_n == (w_out_layer ? NW'(N_OUT - 1) : NW'(N_MID - 1)));
  assign w_done_fire = r_fire && w_out_layer && w_last_n;
  // Layer l reads the buffer written by layer l-1: even layers write act0, odd layers act1.
  assign w_x         = (r_layer == '0) ? r_xq :
                       (r_layer[0] ? r_act0[r_i[MW-1:0]] : r_act1[r_i[MW-1:0]]);
  assign w_sum       = {1'b0, r_acc} + {1'b0, r_bq};
  assign w_half      = (CW+1)'(w_fan_in >> 1);
  assign w_fire      = (w_sum > w_half);
  assign w_take      = (r_n == '0) || (w_sum > r_max);
  assign w_cfg_ok    = xrst && (r_state == S_LOAD) && (r_pcnt == '0);

  // Weights are laid out in evaluation order, so the read pointer only advances on accumulate cycles.
  always_comb begin
    w_state_next = r_state;
    w_i_next     = '0;
    w_widx_next  = '0;
    case (r_state)
      S_LOAD:    if (w_hs && w_last_pix) w_state_next = S_COMPUTE;
      S_COMPUTE: begin
        if (!r_fire) begin
          w_widx_next = r_widx + WAW'(1);
          if (!w_last_i) w_i_next = r_i + IW'(1);
        end else if (w_done_fire) begin
          w_state_next = S_DONE;
        end else begin
          w_widx_next = r_widx;
        end
      end
      S_DONE:    w_state_next = S_LOAD;
      default:   w_state_next = S_LOAD;
    endcase
  end

  always_comb begin
    w_ovec_new = r_ovec;
    for (int k = 0; k < N_OUT; k++)
      if (r_n == NW'(k)) w_ovec_new[k] = w_fire;
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      r_state      <= S_LOAD;
      r_pcnt       <= '0;
      r_i          <= '0;
      r_layer      <= '0;
      r_n          <= '0;
      r_fire       <= 1'b0;
      r_acc        <= '0;
      r_widx       <= '0;
      r_bidx       <= '0;
      r_max        <= '0;
      r_idx        <= '0;
      r_ovec       <= '0;
      r_pred       <= '0;
      r_pred_idx   <= '0;
      r_pred_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_widx       <= w_widx_next;
      r_i          <= w_i_next;
      r_pred_valid <= 1'b0;
      if (r_state == S_LOAD) begin
        r_layer <= '0;
        r_n     <= '0;
        r_fire  <= 1'b0;
        r_acc   <= '0;
        r_bidx  <= '0;
        if (w_hs) r_pcnt <= w_last_pix ? '0 : r_pcnt + IW'(1);
      end else if (r_state == S_COMPUTE) begin
        if (!r_fire) begin
          r_acc  <= r_acc + CW'(r_wq == w_x);
          r_fire <= w_last_i;
        end else begin
          r_acc  <= '0;
          r_fire <= 1'b0;
          r_bidx <= r_bidx + BAW'(1);
          if (w_out_layer) begin
            r_ovec <= w_ovec_new;
            if (w_take) begin
              r_max <= w_sum;
              r_idx <= XW'(r_n);
            end
            if (w_last_n) begin
              r_pred       <= w_ovec_new;
              r_pred_idx   <= w_take ? XW'(r_n) : r_idx;
              r_pred_valid <= 1'b1;
            end
          end
          if (w_last_n) begin
            r_n     <= '0;
            r_layer <= r_layer + LW'(1);
          end else begin
            r_n <= r_n + NW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_COMPUTE && r_fire && !w_out_layer) begin
      for (int k = 0; k < N_MID; k++) begin
        if (r_n == NW'(k)) begin
          if (r_layer[0]) r_act1[k] <= w_fire;
          else            r_act0[k] <= w_fire;
        end
      end
    end
  end

  // Image, weight and bias stores are plain RAMs with registered reads; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_hs) r_img[r_pcnt] <= (pix > PIX_W'(PIX_TH));
    r_xq <= r_img[w_i_next];
    r_wq <= r_wmem[w_widx_next];
    r_bq <= r_bmem[r_bidx];
    if (w_cfg_ok && cfg_we && (cfg_waddr < 32'(W_TOT))) r_wmem[cfg_waddr[WAW-1:0]] <= cfg_wbit;
    if (w_cfg_ok && cfg_be && (cfg_baddr < 16'(B_TOT))) r_bmem[cfg_baddr[BAW-1:0]] <= cfg_bias;
  end

endmodule

// File: tb/tb_bnn_seq.sv
// Bench for bnn_seq on a reduced network: per-cycle comparison against a layer-by-layer
// popcount model, plus directed images with hand-derived expected classes.
module tb_bnn_seq;
  localparam int N_IN = 49, N_MID = 8, N_OUT = 5, DEPTH = 3, PIX_W = 8, PIX_TH = 64, CW = 8;
  localparam int W_TOT = N_MID * N_IN + (DEPTH - 1) * N_MID * N_MID + N_OUT * N_MID;
  localparam int B_TOT = DEPTH * N_MID + N_OUT;
  localparam int L = N_MID * (N_IN + 1) + (DEPTH - 1) * N_MID * (N_MID + 1) + N_OUT * (N_MID + 1);
  localparam int XW = $clog2(N_OUT);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic xrst, pix_valid, pix_ready, cfg_we, cfg_wbit, cfg_be, busy, pred_valid;
  logic [PIX_W-1:0] pix;
  logic [31:0] cfg_waddr;
  logic [15:0] cfg_baddr;
  logic [CW-1:0] cfg_bias;
  logic [N_OUT-1:0] pred;
  logic [XW-1:0] pred_idx;

  bnn_seq #(.N_IN(N_IN), .N_MID(N_MID), .N_OUT(N_OUT), .DEPTH(DEPTH),
            .PIX_W(PIX_W), .PIX_TH(PIX_TH), .CW(CW)) dut (
    .clk(clk), .xrst(xrst), .pix(pix), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wbit(cfg_wbit), .cfg_be(cfg_be),
    .cfg_baddr(cfg_baddr), .cfg_bias(cfg_bias), .busy(busy), .pred(pred),
    .pred_idx(pred_idx), .pred_valid(pred_valid));

  int checks = 0, errors = 0;
  bit m_w [W_TOT];
  int m_b [B_TOT];
  bit m_img [N_IN];
  bit m_init = 0, m_load = 1;
  int m_pix = 0, m_ctr = 0, m_idx = 0;
  logic [N_OUT-1:0] m_pred;
  int img_buf [N_IN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Network evaluated layer by layer straight from the weight/bias address maps.
  function automatic void model_run(output logic [N_OUT-1:0] p, output int idx);
    int xv[$], yv[$];
    int fan, nn, wbase, cnt, sum, best;
    bit f;
    xv = {};
    for (int i = 0; i < N_IN; i++) xv.push_back(int'(m_img[i]));
    p = '0; idx = 0; best = -1;
    for (int l = 0; l <= DEPTH; l++) begin
      fan = (l == 0) ? N_IN : N_MID;
      nn = (l == DEPTH) ? N_OUT : N_MID;
      wbase = (l == 0) ? 0 : N_MID * N_IN + (l - 1) * N_MID * N_MID;
      yv = {};
      for (int n = 0; n < nn; n++) begin
        cnt = 0;
        for (int i = 0; i < fan; i++) if (int'(m_w[wbase + n * fan + i]) == xv[i]) cnt++;
        sum = cnt + m_b[l * N_MID + n];
        f = (sum > fan / 2);
        yv.push_back(int'(f));
        if (l == DEPTH) begin
          p[n] = f;
          if (sum > best) begin best = sum; idx = n; end
        end
      end
      xv = yv;
    end
  endfunction

  initial forever begin
    @(posedge clk);
    if (xrst !== 1'b1) begin
      m_init = 1; m_load = 1; m_pix = 0; m_ctr = 0; m_pred = '0; m_idx = 0;
    end else if (m_init) begin
      if (m_load && m_pix == 0) begin
        if (cfg_we && cfg_waddr < W_TOT) m_w[int'(cfg_waddr)] = cfg_wbit;
        if (cfg_be && cfg_baddr < B_TOT) m_b[int'(cfg_baddr)] = int'(cfg_bias);
      end
      if (m_load) begin
        if (pix_valid) begin
          m_img[m_pix] = (pix > PIX_TH);
          m_pix++;
          if (m_pix == N_IN) begin m_load = 0; m_pix = 0; m_ctr = 1; end
        end
      end else begin
        m_ctr++;
        if (m_ctr == L + 1) model_run(m_pred, m_idx);
        else if (m_ctr == L + 2) begin m_load = 1; m_ctr = 0; end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("pix_ready", pix_ready, xrst && m_load);
      chk("busy", busy, !m_load);
      chk("pred_valid", pred_valid, !m_load && m_ctr == L + 1);
      chk("pred", pred, m_pred);
      chk("pred_idx", pred_idx, m_idx);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_w(input int a, input bit b);
    cfg_waddr = a; cfg_wbit = b; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_b(input int a, input int v);
    cfg_baddr = 16'(a); cfg_bias = CW'(v); cfg_be = 1'b1;
    tick();
    cfg_be = 1'b0;
  endtask

  task automatic set_all(input int wmode, input int bmax);
    for (int a = 0; a < W_TOT; a++) cfg_w(a, (wmode == 2) ? bit'($urandom_range(0, 1)) : bit'(wmode));
    for (int a = 0; a < B_TOT; a++) cfg_b(a, $urandom_range(0, bmax));
  endtask

  task automatic fill_img(input int v);
    for (int p = 0; p < N_IN; p++) img_buf[p] = (v < 0) ? $urandom_range(0, 255) : v;
  endtask

  task automatic send_image(input int gap_max, input bit poke);
    int t;
    for (int p = 0; p < N_IN; p++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      pix = PIX_W'(img_buf[p]); pix_valid = 1'b1;
      if (poke && p > 0) begin
        cfg_we = 1'b1; cfg_waddr = $urandom_range(0, W_TOT - 1); cfg_wbit = 1'($urandom);
        cfg_be = 1'b1; cfg_baddr = 16'($urandom_range(0, B_TOT - 1)); cfg_bias = CW'($urandom);
      end
      t = 0;
      @(negedge clk);
      while (!pix_ready && t < 50) begin @(negedge clk); t++; end
      if (!pix_ready) chk("pix_accept", pix_ready, 1);
      tick();
      pix_valid = 1'b0; cfg_we = 1'b0; cfg_be = 1'b0;
    end
  endtask

  task automatic run_img(input string tag, input int gap, input bit hold, input bit poke,
                         output logic [N_OUT-1:0] p, output logic [XW-1:0] ix);
    int lat;
    bit got;
    send_image(gap, poke);
    lat = 0; got = 0;
    while (!got && lat < L + 20) begin
      if (hold) begin pix_valid = 1'b1; pix = PIX_W'($urandom); end
      if (poke) begin
        cfg_we = 1'b1; cfg_waddr = $urandom_range(0, W_TOT - 1); cfg_wbit = 1'($urandom);
        cfg_be = 1'b1; cfg_baddr = 16'($urandom_range(0, B_TOT - 1)); cfg_bias = CW'($urandom);
      end
      @(negedge clk);
      lat++;
      if (pred_valid === 1'b1) got = 1;
    end
    pix_valid = 1'b0; cfg_we = 1'b0; cfg_be = 1'b0;
    p = pred; ix = pred_idx;
    chk({tag, "_done"}, 32'(got), 1);
    chk({tag, "_latency"}, lat, L + 1);
    $display("image %s: pred=%h idx=%0d latency=%0d", tag, p, ix, lat);
    tick();
  endtask

  logic [N_OUT-1:0] p0, p1;
  logic [XW-1:0] i0, i1;
  int seen;

  initial begin
    xrst = 1'b0; pix = '0; pix_valid = 1'b0; cfg_we = 1'b0; cfg_waddr = '0; cfg_wbit = 1'b0;
    cfg_be = 1'b0; cfg_baddr = '0; cfg_bias = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pred", pred, 0);
    chk("rst_idx", pred_idx, 0);
    chk("rst_valid", pred_valid, 0);
    chk("rst_ready", pix_ready, 0);
    @(posedge clk); #1;
    xrst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", pix_ready, 1);
    chk("post_rst_busy", busy, 0);
    tick();

    set_all(1, 0);
    fill_img(255); run_img("ones", 0, 0, 0, p0, i0);
    chk("ones_pred", p0, 5'h1F); chk("ones_idx", i0, 0);
    fill_img(64);  run_img("at_th", 0, 0, 0, p0, i0);
    chk("th64_pred", p0, 0); chk("th64_idx", i0, 0);
    fill_img(65);  run_img("above_th", 0, 0, 0, p0, i0);
    chk("th65_pred", p0, 5'h1F);

    // Only layer-0 neuron 0 can light the network; it sees exactly half (rounded down) matches.
    set_all(0, 0);
    for (int i = 0; i < N_IN / 2; i++) cfg_w(i, 1);
    for (int a = N_MID * N_IN; a < W_TOT; a++) cfg_w(a, 1);
    for (int n = 0; n < N_MID; n++) cfg_b(N_MID + n, N_MID / 2);
    fill_img(255); run_img("tie_bias0", 0, 0, 0, p0, i0);
    chk("tie_bias0_pred", p0, 0);
    cfg_b(0, 1);
    run_img("tie_bias1", 0, 0, 0, p0, i0);
    chk("tie_bias1_pred", p0, 5'h1F);

    set_all(1, 0);
    cfg_b(DEPTH * N_MID + 3, 5);
    cfg_w(W_TOT, 0); cfg_b(B_TOT, 99);
    run_img("argmax", 0, 0, 0, p0, i0);
    chk("argmax_pred", p0, 5'h1F); chk("argmax_idx", i0, 3);

    for (int r = 0; r < 3; r++) begin
      set_all(2, 4);
      fill_img(-1);
      run_img("rand_plain", 0, 0, 0, p0, i0);
      run_img("rand_gappy", 3, 1, 1, p1, i1);
      chk("gap_pred_same", p1, p0); chk("gap_idx_same", i1, i0);
    end

    send_image(0, 0);
    repeat (300) @(negedge clk);
    @(posedge clk); #1;
    xrst = 1'b0;
    tick();
    xrst = 1'b1;
    seen = 0;
    repeat (L + 30) begin
      @(negedge clk);
      if (pred_valid === 1'b1) seen++;
    end
    chk("abort_no_valid", seen, 0);
    tick();
    run_img("after_abort", 1, 0, 0, p1, i1);
    chk("abort_pred_same", p1, p0); chk("abort_idx_same", i1, i0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
